ipg_tx_sched: RTL and testbench

IPG_TX_SCHED -- requirements
Module: ipg_tx_sched

---
 rtl/ipg_pkg.sv | 20 ++
 rtl/ipg_rr_arbiter.sv | 34 +++
 rtl/ipg_tx_sched.sv | 122 ++++++++++++
 tb/tb_ipg_tx_sched.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipg_pkg.sv
// rtl/ipg_pkg.sv - shared constants, state encoding and block-type check for the IPG TX scheduler
package ipg_pkg;

  localparam int IPG_NUM_REQ    = 3;
  localparam int IPG_DATA_WIDTH = 64;

  localparam logic [7:0] BT_READ  = 8'h1a;
  localparam logic [7:0] BT_WRITE = 8'h1b;
  localparam logic [7:0] BT_RRESP = 8'h1c;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic is_legal_type(input logic [7:0] t);
    return (t == BT_READ) || (t == BT_WRITE) || (t == BT_RRESP);
  endfunction

endpackage

// File: rtl/ipg_rr_arbiter.sv
// rtl/ipg_rr_arbiter.sv - combinational round-robin selector starting the search at i_rr_ptr
module ipg_rr_arbiter
  import ipg_pkg::*;
#(
  parameter int NUM_REQ = IPG_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [1:0]         i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant_oh,
  output logic [1:0]         o_grant_bin,
  output logic               o_any_req
);

  // Nested loops keep every vector index a loop constant.
  always_comb begin : p_arb
    int idx;
    o_grant_oh  = '0;
    o_grant_bin = '0;
    o_any_req   = 1'b0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(i_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!o_any_req && (idx == j) && i_req[j]) begin
          o_any_req     = 1'b1;
          o_grant_oh[j] = 1'b1;
          o_grant_bin   = 2'(j);
        end
      end
    end
  end

endmodule

// File: rtl/ipg_tx_sched.sv
// rtl/ipg_tx_sched.sv - schedules whole multi-chunk IPG messages into idle TX slots
module ipg_tx_sched
  import ipg_pkg::*;
#(
  parameter int NUM_REQ    = IPG_NUM_REQ,
  parameter int DATA_WIDTH = IPG_DATA_WIDTH,
  parameter int MAX_CHUNKS = 10,
  parameter int STALL_MAX  = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          slot_avail,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  output logic [1:0]                    tx_grant_id,
  output logic                          err_timeout,
  output logic                          err_type
);

  localparam logic [3:0] LP_MAX_CHUNKS = 4'(MAX_CHUNKS);
  localparam logic [3:0] LP_STALL_MAX  = 4'(STALL_MAX);

  state_e                  r_state, w_next_state;
  logic [1:0]              r_grant, r_rr_ptr, w_grant_inc;
  logic [NUM_REQ-1:0]      r_grant_oh;
  logic [3:0]              r_chunk_cnt, r_stall_cnt;
  logic [NUM_REQ-1:0]      w_arb_oh;
  logic [1:0]              w_arb_bin;
  logic                    w_arb_any;
  logic                    w_sel_valid, w_sel_last, w_legal;
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic                    w_accept, w_starve, w_len_abort, w_stall_abort, w_release;

  ipg_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req       (req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant_oh  (w_arb_oh),
    .o_grant_bin (w_arb_bin),
    .o_any_req   (w_arb_any)
  );

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_oh[i]) begin
        w_sel_valid = req_valid[i];
        w_sel_last  = req_last[i];
        w_sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Aborts and normal completion all release the grant through the same path.
  assign w_legal       = is_legal_type(w_sel_data[7:0]);
  assign w_accept      = (r_state == ST_GRANT) && slot_avail && w_sel_valid;
  assign w_starve      = (r_state == ST_GRANT) && slot_avail && !w_sel_valid;
  assign w_len_abort   = w_accept && !w_sel_last && ((r_chunk_cnt + 4'd1) == LP_MAX_CHUNKS);
  assign w_stall_abort = w_starve && ((r_stall_cnt + 4'd1) == LP_STALL_MAX);
  assign w_release     = (w_accept && w_sel_last) || w_len_abort || w_stall_abort;
  assign w_grant_inc   = (r_grant == 2'(NUM_REQ - 1)) ? 2'd0 : r_grant + 2'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_arb_any) w_next_state = ST_GRANT;
      ST_GRANT: if (w_release) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (r_state == ST_GRANT) req_ready = req_valid & r_grant_oh & {NUM_REQ{slot_avail}};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant     <= '0;
      r_grant_oh  <= '0;
      r_rr_ptr    <= '0;
      r_chunk_cnt <= '0;
      r_stall_cnt <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      tx_grant_id <= '0;
      err_timeout <= 1'b0;
      err_type    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_arb_any) begin
        r_grant    <= w_arb_bin;
        r_grant_oh <= w_arb_oh;
      end
      if (w_release) r_rr_ptr <= w_grant_inc;

      if (w_release)     r_chunk_cnt <= '0;
      else if (w_accept) r_chunk_cnt <= r_chunk_cnt + 4'd1;

      if (w_release || w_accept) r_stall_cnt <= '0;
      else if (w_starve)         r_stall_cnt <= r_stall_cnt + 4'd1;

      tx_valid <= w_accept && w_legal;
      if (w_accept && w_legal) begin
        tx_data     <= w_sel_data;
        tx_grant_id <= r_grant;
      end
      err_type    <= w_accept && !w_legal;
      err_timeout <= w_len_abort || w_stall_abort;
    end
  end

endmodule

// File: tb/tb_ipg_tx_sched.sv
// tb/tb_ipg_tx_sched.sv - scoreboard bench for ipg_tx_sched
module tb_ipg_tx_sched;

  typedef struct {
    logic [63:0] d;
    logic        last;
  } chunk_t;

  typedef struct {
    logic [63:0] d;
    logic [1:0]  id;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [2:0]   req_valid = '0;
  logic [2:0]   req_last = '0;
  logic [191:0] req_data = '0;
  logic [2:0]   req_ready;
  logic         slot_avail = 1'b0;
  logic [63:0]  tx_data;
  logic         tx_valid;
  logic [1:0]   tx_grant_id;
  logic         err_timeout;
  logic         err_type;

  ipg_tx_sched dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .slot_avail  (slot_avail),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_grant_id (tx_grant_id),
    .err_timeout (err_timeout),
    .err_type    (err_type)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  chunk_t rq0[$], rq1[$], rq2[$];
  exp_t   exp_q[$];
  int     budget[3];
  int     seq = 0;
  int     cyc = 0;
  bit     slot_toggle = 0;

  int     acc_first[3], acc_last[3], acc_n[3];
  int     txv_first, txv_last, n_tx;
  int     n_tmo, tmo_cyc, n_etype, etype_cyc;
  int     owners[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic int rq_size(input int i);
    case (i)
      0:       return rq0.size();
      1:       return rq1.size();
      default: return rq2.size();
    endcase
  endfunction

  function automatic chunk_t rq_head(input int i);
    case (i)
      0:       return rq0[0];
      1:       return rq1[0];
      default: return rq2[0];
    endcase
  endfunction

  task automatic rq_pop(input int i);
    case (i)
      0:       void'(rq0.pop_front());
      1:       void'(rq1.pop_front());
      default: void'(rq2.pop_front());
    endcase
  endtask

  task automatic rq_push(input int i, input logic [7:0] typ, input bit last);
    chunk_t c;
    seq++;
    c.d    = {8'(i), 16'(seq), $urandom(), typ};
    c.last = last;
    case (i)
      0:       rq0.push_back(c);
      1:       rq1.push_back(c);
      default: rq2.push_back(c);
    endcase
  endtask

  task automatic push_msg(input int i, input logic [7:0] typ, input int n, input bit with_last);
    for (int k = 0; k < n; k++) rq_push(i, typ, with_last && (k == n - 1));
  endtask

  task automatic clear_all();
    rq0.delete(); rq1.delete(); rq2.delete(); exp_q.delete(); owners.delete();
    for (int i = 0; i < 3; i++) begin
      budget[i] = -1; acc_first[i] = -1; acc_last[i] = -1; acc_n[i] = 0;
    end
    txv_first = -1; txv_last = -1; n_tx = 0;
    n_tmo = 0; tmo_cyc = -1; n_etype = 0; etype_cyc = -1;
    slot_toggle = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; slot_avail = 1'b0;
    clear_all();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc = 1;
  endtask

  task automatic step();
    logic [2:0]   v, l;
    logic [191:0] d;
    chunk_t       c;
    exp_t         e;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < 3; i++) begin
      if (rq_size(i) > 0 && budget[i] != 0) begin
        c = rq_head(i);
        v[i] = 1'b1;
        l[i] = c.last;
        d[i*64 +: 64] = c.d;
      end
    end
    req_valid  = v;
    req_last   = l;
    req_data   = d;
    slot_avail = slot_toggle ? (cyc % 2 == 0) : 1'b1;
    #1;
    if (tx_valid) begin
      if (exp_q.size() == 0) check("tx_unexpected", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check("tx_data", tx_data, e.d);
        check("tx_grant_id", 64'(tx_grant_id), 64'(e.id));
      end
      if (owners.size() == 0 || owners[$] != int'(tx_grant_id)) owners.push_back(int'(tx_grant_id));
      if (txv_first < 0) txv_first = cyc;
      txv_last = cyc;
      n_tx++;
    end
    if (err_timeout) begin n_tmo++; tmo_cyc = cyc; end
    if (err_type)    begin n_etype++; etype_cyc = cyc; end
    check("ready_gate", 64'(((!slot_avail) && (req_ready != 0)) || ($countones(req_ready) > 1)), 64'd0);
    for (int i = 0; i < 3; i++) begin
      if (req_ready[i]) begin
        if (!v[i]) check("ready_without_valid", 64'd1, 64'd0);
        else begin
          c = rq_head(i);
          rq_pop(i);
          if (c.d[7:0] inside {8'h1a, 8'h1b, 8'h1c}) begin
            e.d = c.d; e.id = 2'(i);
            exp_q.push_back(e);
          end
          if (acc_first[i] < 0) acc_first[i] = cyc;
          acc_last[i] = cyc;
          acc_n[i]++;
          if (budget[i] > 0) budget[i]--;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic check_drained(input string tag);
    check(tag, 64'(rq0.size() + rq1.size() + rq2.size() + exp_q.size()), 64'd0);
  endtask

  initial begin
    clear_all();
    #2;
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_data", tx_data, 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_errs", 64'({err_timeout, err_type, tx_grant_id}), 64'd0);

    // Three-chunk message from requester 0
    do_reset();
    push_msg(0, 8'h1c, 3, 1);
    run(7);
    check("t1_acc_first", 64'(acc_first[0]), 64'd2);
    check("t1_acc_last", 64'(acc_last[0]), 64'd4);
    check("t1_txv_first", 64'(txv_first), 64'd3);
    check("t1_txv_last", 64'(txv_last), 64'd5);
    check("t1_n_tx", 64'(n_tx), 64'd3);
    check_drained("t1_drain");

    // All requesters pending: round-robin, whole messages
    do_reset();
    for (int m = 0; m < 2; m++) begin
      push_msg(0, 8'h1c, 2, 1);
      push_msg(1, 8'h1a, 2, 1);
      push_msg(2, 8'h1b, 2, 1);
    end
    run(30);
    check("t2_owner_count", 64'(owners.size()), 64'd6);
    for (int k = 0; k < 6 && k < owners.size(); k++) check("t2_owner_order", 64'(owners[k]), 64'(k % 3));
    check_drained("t2_drain");

    // Slots available only on alternate cycles
    do_reset();
    slot_toggle = 1;
    push_msg(0, 8'h1b, 4, 1);
    run(14);
    check("t3_acc_first", 64'(acc_first[0]), 64'd2);
    check("t3_acc_last", 64'(acc_last[0]), 64'd8);
    check("t3_txv_last", 64'(txv_last), 64'd9);
    check("t3_no_timeout", 64'(n_tmo), 64'd0);
    check_drained("t3_drain");

    // Requester 1 starves after two chunks; requester 2 waiting
    do_reset();
    push_msg(1, 8'h1a, 5, 1);
    budget[1] = 2;
    push_msg(2, 8'h1c, 1, 1);
    run(28);
    check("t4_n_tmo", 64'(n_tmo), 64'd1);
    check("t4_tmo_cyc", 64'(tmo_cyc), 64'(acc_last[1] + 16));
    check("t4_req2_acc", 64'(acc_first[2]), 64'(acc_last[1] + 17));
    check("t4_owners", 64'(owners.size() == 2 && owners[1] == 2), 64'd1);
    rq1.delete();
    check_drained("t4_drain");

    // Length overrun on the tenth chunk
    do_reset();
    push_msg(2, 8'h1c, 11, 0);
    push_msg(2, 8'h1c, 1, 1);
    run(20);
    check("t5_n_tmo", 64'(n_tmo), 64'd1);
    check("t5_tmo_cyc", 64'(tmo_cyc), 64'd12);
    check("t5_acc_n", 64'(acc_n[2]), 64'd12);
    check_drained("t5_drain");

    // Illegal block type in the middle of a message
    do_reset();
    rq_push(0, 8'h1a, 0);
    rq_push(0, 8'h55, 0);
    rq_push(0, 8'h1a, 1);
    run(8);
    check("t6_n_etype", 64'(n_etype), 64'd1);
    check("t6_etype_cyc", 64'(etype_cyc), 64'd4);
    check("t6_n_tx", 64'(n_tx), 64'd2);
    check("t6_no_timeout", 64'(n_tmo), 64'd0);
    check_drained("t6_drain");

    // Asynchronous reset mid-message, then fresh arbitration
    do_reset();
    push_msg(0, 8'h1c, 1, 1);
    push_msg(1, 8'h1a, 5, 1);
    run(6);
    #2;
    reset = 1'b0;
    #1;
    check("t7_rst_tx_valid", 64'(tx_valid), 64'd0);
    check("t7_rst_tx_data", tx_data, 64'd0);
    check("t7_rst_ready", 64'(req_ready), 64'd0);
    check("t7_rst_id_errs", 64'({tx_grant_id, err_timeout, err_type}), 64'd0);
    do_reset();
    push_msg(1, 8'h1a, 1, 1);
    push_msg(0, 8'h1c, 1, 1);
    run(8);
    check("t7_first_owner", 64'(owners.size() > 0 ? owners[0] : 9), 64'd0);
    check("t7_no_err", 64'(n_tmo + n_etype), 64'd0);
    check_drained("t7_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
